// File: rtl/periph_bus_arbiter.sv
// periph_bus_arbiter
// Merges the instruction-fetch master (m0) and the load/store master (m1)
// onto the single registered io_* peripheral bus request. The arbiter
// follows one transaction through issue, response and drain. It returns
// the read data, or a timeout error, to the master that owns it.
// Optional feature macro: ARB_ROUND_ROBIN_EN. When it is defined, the
// arbiter alternates grants when both masters contend. When it is not
// defined, m1 has fixed priority over m0.
`ifndef MAX_BIT_POS
`define MAX_BIT_POS 31
`endif

module periph_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  pclk,
  input  logic                  rst_n,
  input  logic [`MAX_BIT_POS:0] m0_addr,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [`MAX_BIT_POS:0] m0_wdata,
  input  logic [1:0]            m0_byte_size,
  output logic [`MAX_BIT_POS:0] m0_rdata,
  output logic                  m0_ready,
  output logic                  m0_err,
  input  logic [`MAX_BIT_POS:0] m1_addr,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [`MAX_BIT_POS:0] m1_wdata,
  input  logic [1:0]            m1_byte_size,
  output logic [`MAX_BIT_POS:0] m1_rdata,
  output logic                  m1_ready,
  output logic                  m1_err,
  output logic [`MAX_BIT_POS:0] io_addr,
  output logic                  io_read,
  output logic                  io_write,
  output logic [`MAX_BIT_POS:0] io_wdata,
  output logic [1:0]            io_byte_size,
  output logic                  read_ready,
  input  logic [`MAX_BIT_POS:0] io_rdata,
  input  logic                  io_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // The last ISSUE cycle before the transaction is abandoned.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t                state, state_nxt;
  logic                  owner, owner_nxt;      // 0 = m0, 1 = m1
  logic [15:0]           cnt, cnt_nxt;
  logic                  m0_pend, m1_pend, pick_m1;

  logic [`MAX_BIT_POS:0] addr_nxt, wdata_nxt, rdata0_nxt, rdata1_nxt;
  logic [1:0]            size_nxt;
  logic                  rd_nxt, wr_nxt, rr_nxt;
  logic                  rdy0_nxt, rdy1_nxt, err0_nxt, err1_nxt;

  assign m0_pend = m0_read | m0_write;
  assign m1_pend = m1_read | m1_write;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_gnt;  // 1 = m1 was granted most recently

  // Remember who won the last grant so contention alternates.
  always_ff @(posedge pclk) begin
    if (!rst_n)
      last_gnt <= 1'b1;
    else if (state == IDLE && (m0_pend || m1_pend))
      last_gnt <= pick_m1;
  end

  // On contention, the master that did not win last time gets the bus.
  always_comb begin
    pick_m1 = m1_pend && (!m0_pend || !last_gnt);
  end
`else
  // Fixed priority: data traffic (m1) always beats fetch (m0).
  always_comb begin
    pick_m1 = m1_pend;
  end
`endif

  // Next-state and next-output decode. The bus attributes hold their
  // values by default, and the response pulses default to zero.
  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    cnt_nxt    = cnt;
    addr_nxt   = io_addr;
    wdata_nxt  = io_wdata;
    size_nxt   = io_byte_size;
    rd_nxt     = io_read;
    wr_nxt     = io_write;
    rr_nxt     = 1'b0;
    rdy0_nxt   = 1'b0;
    rdy1_nxt   = 1'b0;
    err0_nxt   = 1'b0;
    err1_nxt   = 1'b0;
    rdata0_nxt = '0;
    rdata1_nxt = '0;
    case (state)
      IDLE: begin
        if (m0_pend || m1_pend) begin
          owner_nxt = pick_m1;
          cnt_nxt   = '0;
          state_nxt = ISSUE;
          // A master that drives both strobes gets a write; its read is ignored.
          if (pick_m1) begin
            addr_nxt  = m1_addr;
            wdata_nxt = m1_wdata;
            size_nxt  = m1_byte_size;
            wr_nxt    = m1_write;
            rd_nxt    = m1_read & ~m1_write;
          end else begin
            addr_nxt  = m0_addr;
            wdata_nxt = m0_wdata;
            size_nxt  = m0_byte_size;
            wr_nxt    = m0_write;
            rd_nxt    = m0_read & ~m0_write;
          end
        end
      end
      ISSUE: begin
        if (io_ready || cnt == TO_LAST) begin
          state_nxt = RESP;
          rd_nxt    = 1'b0;
          wr_nxt    = 1'b0;
          rr_nxt    = 1'b1;
          // A completion that arrives on the last allowed cycle still counts as success.
          if (owner) begin
            rdy1_nxt   = 1'b1;
            err1_nxt   = ~io_ready;
            rdata1_nxt = io_ready ? io_rdata : '0;
          end else begin
            rdy0_nxt   = 1'b1;
            err0_nxt   = ~io_ready;
            rdata0_nxt = io_ready ? io_rdata : '0;
          end
        end else if (cnt != 16'hFFFF) begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      RESP: begin
        state_nxt = DRAIN;
      end
      DRAIN: begin
        // The bus must drop io_ready before it can accept a new request.
        if (!io_ready)
          state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register. Every output is registered here, so no input reaches an output combinationally.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state        <= IDLE;
      owner        <= 1'b0;
      cnt          <= '0;
      io_addr      <= '0;
      io_wdata     <= '0;
      io_byte_size <= '0;
      io_read      <= 1'b0;
      io_write     <= 1'b0;
      read_ready   <= 1'b0;
      m0_ready     <= 1'b0;
      m1_ready     <= 1'b0;
      m0_err       <= 1'b0;
      m1_err       <= 1'b0;
      m0_rdata     <= '0;
      m1_rdata     <= '0;
    end else begin
      state        <= state_nxt;
      owner        <= owner_nxt;
      cnt          <= cnt_nxt;
      io_addr      <= addr_nxt;
      io_wdata     <= wdata_nxt;
      io_byte_size <= size_nxt;
      io_read      <= rd_nxt;
      io_write     <= wr_nxt;
      read_ready   <= rr_nxt;
      m0_ready     <= rdy0_nxt;
      m1_ready     <= rdy1_nxt;
      m0_err       <= err0_nxt;
      m1_err       <= err1_nxt;
      m0_rdata     <= rdata0_nxt;
      m1_rdata     <= rdata1_nxt;
    end
  end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Testbench for periph_bus_arbiter: directed scenarios plus randomized
// master and bus traffic, checked every cycle against a transaction-level model.
`ifndef MAX_BIT_POS
`define MAX_BIT_POS 31
`endif

module tb_periph_bus_arbiter;
  localparam int XW = `MAX_BIT_POS + 1;
  localparam int TO = 8;

  logic          pclk = 1'b0;
  logic          rst_n;
  logic [XW-1:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic          m0_read, m0_write, m0_ready, m0_err;
  logic          m1_read, m1_write, m1_ready, m1_err;
  logic [1:0]    m0_byte_size, m1_byte_size, io_byte_size;
  logic [XW-1:0] io_addr, io_wdata, io_rdata;
  logic          io_read, io_write, read_ready, io_ready;

  periph_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .pclk(pclk), .rst_n(rst_n),
    .m0_addr(m0_addr), .m0_read(m0_read), .m0_write(m0_write), .m0_wdata(m0_wdata),
    .m0_byte_size(m0_byte_size), .m0_rdata(m0_rdata), .m0_ready(m0_ready), .m0_err(m0_err),
    .m1_addr(m1_addr), .m1_read(m1_read), .m1_write(m1_write), .m1_wdata(m1_wdata),
    .m1_byte_size(m1_byte_size), .m1_rdata(m1_rdata), .m1_ready(m1_ready), .m1_err(m1_err),
    .io_addr(io_addr), .io_read(io_read), .io_write(io_write), .io_wdata(io_wdata),
    .io_byte_size(io_byte_size), .read_ready(read_ready), .io_rdata(io_rdata), .io_ready(io_ready)
  );

  always #5 pclk = ~pclk;

  int errs = 0;
  int checks = 0;
  bit cmp_en = 1'b0;
  bit auto_m = 1'b0;
  bit auto_b = 1'b0;

  function automatic void check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endfunction

  // ---------------- transaction-level reference model ----------------
  bit            busy, done, own, p0, p1;
  int unsigned   ecnt = 0;
  int unsigned   t_grant, t_done;
`ifdef ARB_ROUND_ROBIN_EN
  bit            last_m1;
`endif
  logic [XW-1:0] e_io_addr, e_io_wdata, e_m0_rdata, e_m1_rdata;
  logic [1:0]    e_io_byte_size;
  logic          e_io_read, e_io_write, e_read_ready, e_m0_ready, e_m1_ready, e_m0_err, e_m1_err;

  always @(posedge pclk) begin
    if (!rst_n) begin
      busy = 0; done = 0;
`ifdef ARB_ROUND_ROBIN_EN
      last_m1 = 1;
`endif
      e_io_addr = '0; e_io_wdata = '0; e_io_byte_size = '0; e_io_read = 0; e_io_write = 0;
      e_read_ready = 0; e_m0_ready = 0; e_m1_ready = 0; e_m0_err = 0; e_m1_err = 0;
      e_m0_rdata = '0; e_m1_rdata = '0;
    end else begin
      e_read_ready = 0; e_m0_ready = 0; e_m1_ready = 0; e_m0_err = 0; e_m1_err = 0;
      e_m0_rdata = '0; e_m1_rdata = '0;
      if (!busy) begin
        p0 = m0_read | m0_write;
        p1 = m1_read | m1_write;
        if (p0 || p1) begin
`ifdef ARB_ROUND_ROBIN_EN
          own = p1 && (!p0 || !last_m1);
          last_m1 = own;
`else
          own = p1;
`endif
          busy = 1; done = 0; t_grant = ecnt;
          if (own) begin
            e_io_addr = m1_addr; e_io_wdata = m1_wdata; e_io_byte_size = m1_byte_size;
            e_io_write = m1_write; e_io_read = m1_read && !m1_write;
          end else begin
            e_io_addr = m0_addr; e_io_wdata = m0_wdata; e_io_byte_size = m0_byte_size;
            e_io_write = m0_write; e_io_read = m0_read && !m0_write;
          end
        end
      end else if (!done) begin
        if (io_ready || (ecnt - t_grant) >= TO) begin
          done = 1; t_done = ecnt;
          e_io_read = 0; e_io_write = 0; e_read_ready = 1;
          if (own) begin
            e_m1_ready = 1; e_m1_err = !io_ready; e_m1_rdata = io_ready ? io_rdata : '0;
          end else begin
            e_m0_ready = 1; e_m0_err = !io_ready; e_m0_rdata = io_ready ? io_rdata : '0;
          end
        end
      end else if (ecnt >= t_done + 2 && !io_ready) begin
        busy = 0;
      end
    end
    ecnt++;
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge pclk) begin
    if (cmp_en) begin
      check("cyc_io_addr", 64'(io_addr), 64'(e_io_addr));
      check("cyc_io_wdata", 64'(io_wdata), 64'(e_io_wdata));
      check("cyc_io_byte_size", 64'(io_byte_size), 64'(e_io_byte_size));
      check("cyc_io_read", 64'(io_read), 64'(e_io_read));
      check("cyc_io_write", 64'(io_write), 64'(e_io_write));
      check("cyc_read_ready", 64'(read_ready), 64'(e_read_ready));
      check("cyc_m0_ready", 64'(m0_ready), 64'(e_m0_ready));
      check("cyc_m1_ready", 64'(m1_ready), 64'(e_m1_ready));
      check("cyc_m0_err", 64'(m0_err), 64'(e_m0_err));
      check("cyc_m1_err", 64'(m1_err), 64'(e_m1_err));
      check("cyc_m0_rdata", 64'(m0_rdata), 64'(e_m0_rdata));
      check("cyc_m1_rdata", 64'(m1_rdata), 64'(e_m1_rdata));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge pclk);
    if (m0_ready) begin
      m0_read = 0; m0_write = 0;
    end else if (auto_m) begin
      if (!(m0_read || m0_write)) begin
        if ($urandom_range(0, 3) == 0) begin
          m0_addr = XW'($urandom); m0_wdata = XW'($urandom); m0_byte_size = 2'($urandom);
          {m0_write, m0_read} = 2'($urandom_range(1, 3));
        end
      end else if ($urandom_range(0, 7) == 0) begin
        m0_addr = XW'($urandom); m0_wdata = XW'($urandom); m0_byte_size = 2'($urandom);
      end
    end
    if (m1_ready) begin
      m1_read = 0; m1_write = 0;
    end else if (auto_m) begin
      if (!(m1_read || m1_write)) begin
        if ($urandom_range(0, 3) == 0) begin
          m1_addr = XW'($urandom); m1_wdata = XW'($urandom); m1_byte_size = 2'($urandom);
          {m1_write, m1_read} = 2'($urandom_range(1, 3));
        end
      end else if ($urandom_range(0, 7) == 0) begin
        m1_addr = XW'($urandom); m1_wdata = XW'($urandom); m1_byte_size = 2'($urandom);
      end
    end
    if (auto_b) begin
      io_ready = ($urandom_range(0, 3) == 0);
      io_rdata = XW'($urandom);
    end
  endtask

  task automatic wait_strobe(output int n);
    for (n = 0; n < 40 && !(io_read || io_write); n++) step();
    check("strobe_seen", 64'(io_read | io_write), 64'd1);
  endtask

  task automatic wait_ready(input bit which, output int n);
    for (n = 0; n < 40 && !(which ? m1_ready : m0_ready); n++) step();
    check(which ? "m1_ready_seen" : "m0_ready_seen", 64'(which ? m1_ready : m0_ready), 64'd1);
  endtask

  int n;
  bit got_m1;
  bit exp_m1;

  initial begin
    rst_n = 0; io_ready = 0; io_rdata = '0;
    m0_addr = '0; m0_read = 0; m0_write = 0; m0_wdata = '0; m0_byte_size = '0;
    m1_addr = '0; m1_read = 0; m1_write = 0; m1_wdata = '0; m1_byte_size = '0;
    repeat (2) @(negedge pclk);
    cmp_en = 1;
    check("rst_io_addr", 64'(io_addr), 64'd0);
    check("rst_io_read", 64'(io_read), 64'd0);
    check("rst_io_write", 64'(io_write), 64'd0);
    check("rst_read_ready", 64'(read_ready), 64'd0);
    check("rst_m0_ready", 64'(m0_ready), 64'd0);
    check("rst_m1_rdata", 64'(m1_rdata), 64'd0);
    rst_n = 1;
    step();

    // m0 read, bus answers two cycles after the strobe
    m0_addr = XW'(32'h0000_0100); m0_read = 1;
    wait_strobe(n);
    check("t1_io_read", 64'(io_read), 64'd1);
    check("t1_io_addr", 64'(io_addr), 64'h100);
    step(); step();
    io_ready = 1; io_rdata = XW'(32'hDEAD_BEEF);
    wait_ready(0, n);
    check("t1_m0_rdata", 64'(m0_rdata), 64'(XW'(32'hDEAD_BEEF)));
    check("t1_m0_err", 64'(m0_err), 64'd0);
    check("t1_read_ready", 64'(read_ready), 64'd1);
    check("t1_m1_ready", 64'(m1_ready), 64'd0);
    io_ready = 0;
    step();
    check("t1_pulse_ready", 64'(m0_ready), 64'd0);
    check("t1_pulse_rr", 64'(read_ready), 64'd0);
    step(); step();

    // m1 byte write, attributes changed after grant must be ignored
    m1_addr = XW'(32'h1000_0000); m1_wdata = XW'(32'h0000_00A5); m1_byte_size = 2'd0; m1_write = 1;
    wait_strobe(n);
    check("t2_io_write", 64'(io_write), 64'd1);
    check("t2_io_read", 64'(io_read), 64'd0);
    check("t2_io_addr", 64'(io_addr), 64'h1000_0000);
    check("t2_io_wdata", 64'(io_wdata), 64'hA5);
    check("t2_io_size", 64'(io_byte_size), 64'd0);
    m1_addr = XW'(32'h2222_0000); m1_wdata = XW'(32'h5A); m1_byte_size = 2'd3;
    step();
    check("t2_hold_addr", 64'(io_addr), 64'h1000_0000);
    check("t2_hold_size", 64'(io_byte_size), 64'd0);
    io_ready = 1;
    wait_ready(1, n);
    check("t2_m1_err", 64'(m1_err), 64'd0);
    io_ready = 0;
    step();
    check("t2_pulse", 64'(m1_ready), 64'd0);
    step(); step();

    // both masters contend for four transactions
    m0_addr = XW'(32'h20); m1_addr = XW'(32'h30); m0_read = 1; m1_read = 1;
    for (int k = 0; k < 4; k++) begin
      wait_strobe(n);
      io_ready = 1;
      for (n = 0; n < 20 && !(m0_ready || m1_ready); n++) step();
      got_m1 = m1_ready;
`ifdef ARB_ROUND_ROBIN_EN
      exp_m1 = (k % 2) == 1;
`else
      exp_m1 = 1'b1;
`endif
      check("t3_grant_order", 64'(got_m1), 64'(exp_m1));
      io_ready = 0;
      step();
      if (k < 3) begin
        if (got_m1) m1_read = 1; else m0_read = 1;
      end else begin
        m0_read = 0; m1_read = 0;
      end
    end
    step(); step(); step();

    // m0 read that never completes
    m0_addr = XW'(32'hDEAD_0000); m0_read = 1; io_ready = 0;
    wait_strobe(n);
    wait_ready(0, n);
    check("t4_timeout_latency", 64'(n), 64'd8);
    check("t4_m0_err", 64'(m0_err), 64'd1);
    check("t4_m0_rdata", 64'(m0_rdata), 64'd0);
    check("t4_read_ready", 64'(read_ready), 64'd1);
    m1_addr = XW'(32'h40); m1_read = 1;
    for (n = 0; n < 20 && !io_read; n++) step();
    check("t4_idle_gap", 64'(n), 64'd3);
    io_ready = 1;
    wait_ready(1, n);
    io_ready = 0;
    step(); step();

    // bus keeps io_ready high after completion while m1 waits
    m0_addr = XW'(32'h300); m0_read = 1;
    wait_strobe(n);
    io_ready = 1; io_rdata = XW'(32'h0BAD_F00D);
    wait_ready(0, n);
    check("t5_m0_rdata", 64'(m0_rdata), 64'(XW'(32'h0BAD_F00D)));
    m1_addr = XW'(32'h400); m1_read = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_no_strobe", 64'(io_read | io_write), 64'd0);
    end
    io_ready = 0;
    for (n = 0; n < 20 && !io_read; n++) step();
    check("t5_release_gap", 64'(n), 64'd2);
    check("t5_m1_addr", 64'(io_addr), 64'h400);
    io_ready = 1;
    wait_ready(1, n);
    io_ready = 0;
    step(); step();

    // reset in the middle of an issued read
    m0_addr = XW'(32'h500); m0_read = 1;
    wait_strobe(n);
    step(); step();
    rst_n = 0;
    step();
    check("t6_io_read", 64'(io_read), 64'd0);
    check("t6_io_addr", 64'(io_addr), 64'd0);
    check("t6_m0_ready", 64'(m0_ready), 64'd0);
    m0_read = 0; rst_n = 1;
    step();
    check("t6_no_resp", 64'(m0_ready), 64'd0);
    m0_addr = XW'(32'h600); m0_read = 1;
    wait_strobe(n);
    check("t6_fresh_addr", 64'(io_addr), 64'h600);
    io_ready = 1; io_rdata = XW'(32'h1234_5678);
    wait_ready(0, n);
    check("t6_fresh_rdata", 64'(m0_rdata), 64'(XW'(32'h1234_5678)));
    io_ready = 0;
    step(); step();

    // randomized traffic with occasional resets
    auto_m = 1; auto_b = 1;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (!rst_n) rst_n = 1;
      else if ($urandom_range(0, 399) == 0) rst_n = 0;
    end
    auto_m = 0; auto_b = 0;
    rst_n = 1; io_ready = 0;
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    repeat (20) step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/periph_bus_arbiter.md
# periph_bus_arbiter

Two-master arbiter directly upstream of the peripheral bus. It merges the instruction-fetch port (m0) and the load/store port (m1) onto the single io_* request interface that the peripheral bus decodes. Each granted request has its address, strobes, write data and byte size latched into registers, which then drive the bus. The arbiter tracks the io_ready / read_ready handshake to completion and returns data or a timeout error to the owning master.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255, number of ISSUE-state cycles without io_ready before the transaction is aborted with an error; valid range 1..65535
- Data width is XLEN: every data and address bus is [`MAX_BIT_POS:0], taken from config.v

Ports:
- pclk  in  1  single clock for the whole block
- rst_n  in  1  reset; synchronous, active-low, one clock
- m0_addr / m1_addr  in  XLEN  master request address
- m0_read / m1_read  in  1  level read request
- m0_write / m1_write  in  1  level write request
- m0_wdata / m1_wdata  in  XLEN  write data
- m0_byte_size / m1_byte_size  in  2  access size code, passed through unchanged
- m0_rdata / m1_rdata  out  XLEN  read data, valid while mN_ready=1
- m0_ready / m1_ready  out  1  one-cycle completion pulse
- m0_err / m1_err  out  1  asserted together with mN_ready when the transaction timed out
- io_addr  out  XLEN  registered bus address
- io_read / io_write  out  1  registered bus strobes
- io_wdata  out  XLEN  registered write data
- io_byte_size  out  2  registered size code
- read_ready  out  1  one-cycle acknowledge to the bus that the response was consumed
- io_rdata  in  XLEN  bus read data
- io_ready  in  1  bus completion

## Operation
- FSM states: IDLE, ISSUE, RESP, DRAIN.
- IDLE
  - Samples both masters.
  - A master is pending when its mN_read or mN_write is 1.
  - If the master drives both strobes, it is treated as a write and the read is ignored.
  - On any pending master: grant one, latch its addr, wdata, byte_size and strobe into the io_* registers, load the timeout counter with 0, and go to ISSUE.
- ISSUE
  - io_read or io_write is held at 1; the timeout counter increments each cycle.
  - io_ready=1: capture io_rdata (write transactions capture it too, value don't-care), err=0, go to RESP.
  - Counter reaches TIMEOUT_CYCLES-1 with io_ready=0: captured data=0, err=1, go to RESP.
- RESP (exactly one cycle)
  - Outputs: mN_ready=1 and mN_err=err for the granted master only; mN_rdata=captured data; read_ready=1; io_read=io_write=0.
  - Next state: DRAIN.
- DRAIN
  - read_ready=0.
  - Stay in DRAIN until io_ready=0, then go to IDLE.
  - A timed-out transaction passes straight through DRAIN if io_ready is already 0.
- Master rules
  - A master must drop its strobes in the cycle after it sees mN_ready.
  - Requests are ignored in ISSUE, RESP and DRAIN.
  - Attribute changes after grant are ignored.
- The non-granted master's mN_ready, mN_err and mN_rdata stay at 0 at all times.
- Counter arithmetic: 16-bit unsigned, saturating; compare against TIMEOUT_CYCLES-1.
- Reset mid-transaction: any in-flight transaction is abandoned with no response to either master. State returns to IDLE and all outputs are cleared on the next edge.

## Timing
- Reset value of every output is 0: io_addr, io_wdata, io_byte_size, io_read, io_write, read_ready, mN_rdata, mN_ready, mN_err.
- Request sampled in IDLE at edge t → io strobe high from t+1.
- io_ready first seen high at edge k → RESP outputs visible during cycle k+1 → DRAIN from k+2.
- Minimum round trip: request to mN_ready is 3 cycles when io_ready returns the cycle after the strobe.
- Minimum spacing between back-to-back grants is 4 cycles (IDLE, ISSUE, RESP, DRAIN).
- All outputs come straight from registers; there is no combinational path from inputs to outputs.

## Configuration
- ARB_ROUND_ROBIN_EN
  - Defined: a 1-bit last-grant register, reset to m1. When both masters are pending in IDLE, the master not granted last wins. A lone pending master always wins and updates the register.
  - Undefined: fixed priority, m1 (data) always beats m0 (fetch), so m0 can starve under continuous m1 traffic.

## Test plan
- m0 read 0x0000_0100, bus returns io_ready=1 two cycles after io_read with io_rdata=0xDEAD_BEEF → m0_ready single pulse, m0_rdata=0xDEADBEEF, m0_err=0, read_ready single pulse in the same cycle, m1_ready=0 throughout.
- m1 write addr 0x1000_0000, wdata 0x0000_00A5, byte_size 2'd0 → io_addr, io_wdata and io_byte_size match the latched values while io_write=1; m1_ready pulses once after io_ready.
- m0 and m1 both request in the same cycle, repeated for 4 transactions → with ARB_ROUND_ROBIN_EN the grant order is m0, m1, m0, m1; without it, m1 is granted every time.
- m0 read to an unmapped address with io_ready never asserted, TIMEOUT_CYCLES=8 → m0_ready=1 and m0_err=1 exactly 8 cycles after io_read rises, m0_rdata=0, FSM back in IDLE two cycles later.
- Bus holds io_ready=1 for 3 cycles after completion → the FSM stays in DRAIN, no new io strobe appears until one cycle after io_ready falls, even though m1 is pending.
- rst_n=0 for one edge while in ISSUE → all outputs 0 on the next edge, no mN_ready is produced, and a fresh m0 read afterwards completes normally.
